lane_deskew_unstripe: RTL and testbench
=======================================

LANE_DESKEW_UNSTRIPE -- requirements
Module: lane_deskew_unstripe

Interface
REQ-001 SHALL have parameter MAX_LANES, 16, number of physical lanes (1, 2, 4, 8 or 16).
REQ-002 SHALL have parameter FIFO_DEPTH, 8, entries per lane FIFO (power of two, >= 4).
REQ-003 SHALL have parameter MAX_SKEW, 6, maximum deskew wait in cycles (< FIFO_DEPTH).
REQ-004 SHALL have parameter ALIGN_SYM, 8'hBC, alignment symbol, matched only when its K flag is 1.
REQ-005 SHALL use one clock and a synchronous, active-high reset:
  clk  in  1  clock, all logic on rising edge
  reset  in  1  synchronous active-high reset
  LANESNUMBER  in  5  active lane count (1, 2, 4, 8, 16); any other value behaves as 1
  lane_data  in  MAX_LANES*8  one byte per lane, lane i at bits [8i+7:8i]
  lane_k  in  MAX_LANES  K flag per lane byte
  lane_valid  in  MAX_LANES  per-lane write enable
  out_data  out  MAX_LANES*8  unstriped column, lane i byte at bits [8i+7:8i]
  out_k  out  MAX_LANES  K flags matching out_data
  out_valid  out  1  out_data/out_k hold a valid column this cycle
  aligned  out  1  high while in state ALIGNED
  deskew_err  out  1  one-cycle pulse on deskew failure
  ovf_err  out  1  one-cycle pulse on any lane FIFO overflow
  skew_cycles  out  $clog2(MAX_SKEW+1)  skew measured at last successful alignment

Function
REQ-006 SHALL keep one FIFO per lane (byte + K); lane_valid[i] writes lane i at the clock edge; only lanes 0..N-1 (N = active count) are active; inactive lanes are never written and stay empty.
REQ-007 SHALL allow a write and a pop on the same FIFO in one cycle, including when full; a write to a full FIFO with no pop is an overflow.
REQ-008 SHALL implement states SEARCH and ALIGNED; reset state is SEARCH.
REQ-009 In SEARCH, each active lane whose FIFO head is not a marker (K=1, byte==ALIGN_SYM) SHALL pop and discard its head that cycle; lanes with a marker at the head SHALL hold it.
REQ-010 In SEARCH, when every active lane has a marker at its head, all active lanes SHALL pop together, the marker column SHALL be output, the state SHALL become ALIGNED, and skew_cycles SHALL latch the skew counter value.
REQ-011 Skew counter SHALL clear in SEARCH while no active lane holds a marker, and increment each cycle some but not all active lanes hold one.
REQ-012 When the skew counter reaches MAX_SKEW without alignment, all held markers SHALL be discarded, the counter cleared, and deskew_err pulsed; the state remains SEARCH.
REQ-013 In ALIGNED, when all active FIFOs are non-empty and the heads are all markers or all non-markers, all active lanes SHALL pop and the column SHALL be output.
REQ-014 In ALIGNED, if all active FIFOs are non-empty and heads are a mix of markers and non-markers, the block SHALL pulse deskew_err, flush all FIFOs, output nothing, and return to SEARCH.
REQ-015 In ALIGNED, if any active FIFO is empty, no lane SHALL pop and out_valid SHALL be 0.
REQ-016 Output columns SHALL be registered: out_valid/out_data/out_k update on the edge after the pop decision; minimum latency from a byte presented in cycle n to out_data is cycle n+2.
REQ-017 out_data and out_k bytes of inactive lanes SHALL be 0; out_data/out_k SHALL be 0 whenever out_valid is 0.
REQ-018 Any overflow SHALL pulse ovf_err, flush all FIFOs, clear the skew counter and force SEARCH; it takes priority over deskew_err in the same cycle, and the write causing the overflow is dropped.
REQ-019 A change of LANESNUMBER SHALL flush all FIFOs and force SEARCH on the next edge without pulsing any error flag.

Reset
REQ-020 While reset is high at an edge, all FIFOs SHALL be emptied, state SHALL be SEARCH, skew counter SHALL be 0, and out_data, out_k, out_valid, aligned, deskew_err, ovf_err and skew_cycles SHALL all be 0.
REQ-021 Reset asserted mid-operation SHALL discard all buffered data; the first column out after release requires a new marker alignment.

Verification
REQ-022 4 lanes, markers arriving on all lanes in the same cycle, then bytes 0x01..0x04 -> aligned=1, skew_cycles=0, marker column then out_data[31:0]=0x04030201.
REQ-023 4 lanes, lane 3 marker 3 cycles after lane 0 -> alignment succeeds, skew_cycles=3, lane columns output in matching order.
REQ-024 2 lanes, lane 1 marker 7 cycles late (MAX_SKEW=6) -> deskew_err pulses once, no output, later aligned marker pair aligns.
REQ-025 ALIGNED, 8 lanes, marker on lanes 0-6 but data on lane 7 in same column -> deskew_err pulse, aligned=0, out_valid=0 next cycle.
REQ-026 ALIGNED, lane 2 of 4 stalled while others written 9 times (FIFO_DEPTH=8) -> ovf_err pulse, aligned=0; LANESNUMBER 4->8 mid-stream -> flush, no error pulse.

Source files
------------

// File: rtl/lane_deskew_unstripe.sv
// rtl/lane_deskew_unstripe.sv - per-lane deskew FIFOs with marker alignment and column unstriping
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   LANESNUMBER             active lane count (1,2,4,8,16); any other value acts as 1
//   lane_data/lane_k        one byte + K flag per lane, lane i at [8i+7:8i] / [i]
//   lane_valid              per-lane FIFO write enable
//   out_data/out_k          registered unstriped column (inactive lanes read 0)
//   out_valid               out_data/out_k carry a column this cycle
//   aligned                 high while in ALIGNED
//   deskew_err, ovf_err     one-cycle error pulses
//   skew_cycles             skew measured at the last successful alignment
module lane_deskew_unstripe #(
  parameter int         MAX_LANES  = 16,
  parameter int         FIFO_DEPTH = 8,
  parameter int         MAX_SKEW   = 6,
  parameter logic [7:0] ALIGN_SYM  = 8'hBC
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [4:0]                     LANESNUMBER,
  input  logic [MAX_LANES*8-1:0]         lane_data,
  input  logic [MAX_LANES-1:0]           lane_k,
  input  logic [MAX_LANES-1:0]           lane_valid,
  output logic [MAX_LANES*8-1:0]         out_data,
  output logic [MAX_LANES-1:0]           out_k,
  output logic                           out_valid,
  output logic                           aligned,
  output logic                           deskew_err,
  output logic                           ovf_err,
  output logic [$clog2(MAX_SKEW+1)-1:0]  skew_cycles
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(MAX_SKEW + 1);

  typedef enum logic {S_SEARCH = 1'b0, S_ALIGNED = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [SW-1:0]          skew_q, skew_d, skew_cycles_q, skew_cycles_d;
  logic [4:0]             lanes_q;
  logic [8:0]             mem_q    [MAX_LANES][FIFO_DEPTH];
  logic [AW:0]            wr_ptr_q [MAX_LANES];
  logic [AW:0]            rd_ptr_q [MAX_LANES];

  logic [5:0]             n_lanes;
  logic [MAX_LANES-1:0]   active, empty, full, is_mark, wr_en, wr_ok, pop;
  logic [MAX_LANES*8-1:0] head_data, col_data_d, out_data_q;
  logic [MAX_LANES-1:0]   head_k, col_k_d, out_k_q;
  logic                   all_mark, any_mark, all_nonempty, lane_chg, ovf, flush;
  logic                   col_valid_d, out_valid_q, deskew_d, deskew_q, ovf_q;

  always_comb begin
    n_lanes = 6'd1;
    if ((LANESNUMBER == 5'd2 || LANESNUMBER == 5'd4 || LANESNUMBER == 5'd8 ||
         LANESNUMBER == 5'd16) && (int'(LANESNUMBER) <= MAX_LANES))
      n_lanes = {1'b0, LANESNUMBER};
    active = '0;
    for (int i = 0; i < MAX_LANES; i++) active[i] = (i < int'(n_lanes));
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty     = '0;
    full      = '0;
    is_mark   = '0;
    head_data = '0;
    head_k    = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                 (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
      {head_k[i], head_data[8*i +: 8]} = mem_q[i][rd_ptr_q[i][AW-1:0]];
      is_mark[i] = !empty[i] && head_k[i] && (head_data[8*i +: 8] == ALIGN_SYM);
    end
  end

  assign all_mark     = ((is_mark & active) == active);
  assign any_mark     = |(is_mark & active);
  assign all_nonempty = ((~empty & active) == active);
  assign wr_en        = lane_valid & active;
  assign lane_chg     = (LANESNUMBER != lanes_q);

  always_comb begin
    state_d       = state_q;
    skew_d        = skew_q;
    skew_cycles_d = skew_cycles_q;
    pop           = '0;
    flush         = 1'b0;
    col_valid_d   = 1'b0;
    deskew_d      = 1'b0;
    case (state_q)
      S_SEARCH: begin
        if (all_mark) begin
          pop           = active;
          col_valid_d   = 1'b1;
          state_d       = S_ALIGNED;
          skew_cycles_d = skew_q;
          skew_d        = '0;
        end else if (!any_mark) begin
          pop    = active & ~empty;
          skew_d = '0;
        end else if (skew_q == SW'(MAX_SKEW)) begin
          // Waited too long: drop the held markers along with everything else.
          pop      = active & ~empty;
          skew_d   = '0;
          deskew_d = 1'b1;
        end else begin
          pop    = active & ~empty & ~is_mark;
          skew_d = skew_q + 1'b1;
        end
      end
      S_ALIGNED: begin
        if (all_nonempty) begin
          if (all_mark || !any_mark) begin
            pop         = active;
            col_valid_d = 1'b1;
          end else begin
            deskew_d = 1'b1;
            flush    = 1'b1;
            state_d  = S_SEARCH;
            skew_d   = '0;
          end
        end
      end
      default: state_d = S_SEARCH;
    endcase
    ovf = |(wr_en & full & ~pop);
    // A lane-count change or overflow pre-empts everything decided above.
    if (lane_chg || ovf) begin
      flush         = 1'b1;
      state_d       = S_SEARCH;
      skew_d        = '0;
      skew_cycles_d = skew_cycles_q;
      col_valid_d   = 1'b0;
      deskew_d      = 1'b0;
    end
  end

  assign wr_ok = wr_en & (~full | pop);

  always_comb begin
    col_data_d = '0;
    col_k_d    = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (active[i]) begin
        col_data_d[8*i +: 8] = head_data[8*i +: 8];
        col_k_d[i]           = head_k[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_SEARCH;
      skew_q        <= '0;
      skew_cycles_q <= '0;
      lanes_q       <= LANESNUMBER;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_k_q       <= '0;
      deskew_q      <= 1'b0;
      ovf_q         <= 1'b0;
      for (int i = 0; i < MAX_LANES; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      skew_q        <= skew_d;
      skew_cycles_q <= skew_cycles_d;
      lanes_q       <= LANESNUMBER;
      out_valid_q   <= col_valid_d;
      out_data_q    <= col_valid_d ? col_data_d : '0;
      out_k_q       <= col_valid_d ? col_k_d : '0;
      deskew_q      <= deskew_d;
      ovf_q         <= ovf && !lane_chg;
      for (int i = 0; i < MAX_LANES; i++) begin
        if (flush) begin
          wr_ptr_q[i] <= '0;
          rd_ptr_q[i] <= '0;
        end else begin
          if (wr_ok[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
          if (pop[i])   rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_LANES; i++) begin
      if (wr_ok[i] && !flush)
        mem_q[i][wr_ptr_q[i][AW-1:0]] <= {lane_k[i], lane_data[8*i +: 8]};
    end
  end

  assign out_data    = out_data_q;
  assign out_k       = out_k_q;
  assign out_valid   = out_valid_q;
  assign aligned     = (state_q == S_ALIGNED);
  assign deskew_err  = deskew_q;
  assign ovf_err     = ovf_q;
  assign skew_cycles = skew_cycles_q;

endmodule

// File: tb/tb_lane_deskew_unstripe.sv
// tb/tb_lane_deskew_unstripe.sv - self-checking bench for lane_deskew_unstripe
module tb_lane_deskew_unstripe;
  localparam int ML = 16;
  localparam int FD = 8;
  localparam int MS = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [4:0]        ln;
  logic [ML*8-1:0]   ldata;
  logic [ML-1:0]     lk, lv;
  logic [ML*8-1:0]   out_data;
  logic [ML-1:0]     out_k;
  logic              out_valid, aligned, deskew_err, ovf_err;
  logic [2:0]        skew_cycles;

  lane_deskew_unstripe #(
    .MAX_LANES(ML), .FIFO_DEPTH(FD), .MAX_SKEW(MS), .ALIGN_SYM(8'hBC)
  ) dut (
    .clk(clk), .reset(reset), .LANESNUMBER(ln),
    .lane_data(ldata), .lane_k(lk), .lane_valid(lv),
    .out_data(out_data), .out_k(out_k), .out_valid(out_valid),
    .aligned(aligned), .deskew_err(deskew_err), .ovf_err(ovf_err),
    .skew_cycles(skew_cycles)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: lane FIFOs as queues, alignment state as a flag.
  logic [8:0]      mq [ML][$];
  bit              m_al;
  int              m_skew, m_skc;
  logic [4:0]      m_prev;
  logic [ML*8-1:0] e_data;
  logic [ML-1:0]   e_k;
  bit              e_valid, e_desk, e_ovf;

  int          desk_pulses;
  logic [31:0] obs [$];

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic [3:0]  v;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        eal;
    logic [2:0]  esk;
  } vec_t;
  vec_t        tbl [6];
  logic [31:0] w;
  logic        mkr;
  logic [4:0]  lnsel [6];

  function automatic int lanes_of(input logic [4:0] v);
    case (v)
      5'd1, 5'd2, 5'd4, 5'd8, 5'd16: return int'(v);
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int n, marks, nonempty, skc;
    bit pop [ML];
    bit flush, ovf, nxt_al;
    logic [8:0] mk;
    mk = 9'h1BC;
    e_valid = 1'b0; e_data = '0; e_k = '0; e_desk = 1'b0; e_ovf = 1'b0;
    if (reset) begin
      for (int i = 0; i < ML; i++) mq[i].delete();
      m_al = 1'b0; m_skew = 0; m_skc = 0; m_prev = ln;
      return;
    end
    n = lanes_of(ln); marks = 0; nonempty = 0;
    for (int i = 0; i < n; i++)
      if (mq[i].size() > 0) begin
        nonempty++;
        if (mq[i][0] == mk) marks++;
      end
    for (int i = 0; i < ML; i++) pop[i] = 1'b0;
    flush = 1'b0; nxt_al = m_al; skc = m_skc;
    if (!m_al) begin
      if (marks == n) begin
        for (int i = 0; i < n; i++) pop[i] = 1'b1;
        e_valid = 1'b1; nxt_al = 1'b1; skc = m_skew; m_skew = 0;
      end else if (marks == 0) begin
        for (int i = 0; i < n; i++) pop[i] = (mq[i].size() > 0);
        m_skew = 0;
      end else if (m_skew == MS) begin
        for (int i = 0; i < n; i++) pop[i] = (mq[i].size() > 0);
        m_skew = 0; e_desk = 1'b1;
      end else begin
        for (int i = 0; i < n; i++) pop[i] = (mq[i].size() > 0) && (mq[i][0] != mk);
        m_skew++;
      end
    end else if (nonempty == n) begin
      if (marks == 0 || marks == n) begin
        for (int i = 0; i < n; i++) pop[i] = 1'b1;
        e_valid = 1'b1;
      end else begin
        e_desk = 1'b1; flush = 1'b1; nxt_al = 1'b0; m_skew = 0;
      end
    end
    if (e_valid)
      for (int i = 0; i < n; i++) begin
        e_data[8*i +: 8] = mq[i][0][7:0];
        e_k[i]           = mq[i][0][8];
      end
    ovf = 1'b0;
    for (int i = 0; i < n; i++)
      if (lv[i] && mq[i].size() == FD && !pop[i]) ovf = 1'b1;
    if (ln != m_prev || ovf) begin
      e_ovf = ovf && (ln == m_prev);
      flush = 1'b1; nxt_al = 1'b0; m_skew = 0; skc = m_skc;
      e_valid = 1'b0; e_data = '0; e_k = '0; e_desk = 1'b0;
    end
    if (flush) begin
      for (int i = 0; i < ML; i++) mq[i].delete();
    end else begin
      for (int i = 0; i < n; i++) begin
        if (pop[i]) void'(mq[i].pop_front());
        if (lv[i]) mq[i].push_back({lk[i], ldata[8*i +: 8]});
      end
    end
    m_al = nxt_al; m_skc = skc; m_prev = ln;
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_data"}, out_data, e_data);
    chk({tag, "_k"}, out_k, e_k);
    chk({tag, "_flags"}, {out_valid, aligned, deskew_err, ovf_err, skew_cycles},
        {e_valid, m_al, e_desk, e_ovf, 3'(m_skc)});
    if (out_valid) obs.push_back(out_data[31:0]);
    if (deskew_err) desk_pulses++;
  endtask

  task automatic clear_in();
    lv = '0; lk = '0; ldata = '0;
  endtask

  task automatic set_lane(input int i, input logic k, input logic [7:0] b);
    lv[i] = 1'b1; lk[i] = k; ldata[8*i +: 8] = b;
  endtask

  task automatic do_reset(input logic [4:0] l);
    ln = l; reset = 1'b1; clear_in();
    cycle("rst");
    reset = 1'b0;
    obs.delete(); desk_pulses = 0;
  endtask

  initial begin
    reset = 1'b1; ln = 5'd4; clear_in();
    ldata = {4{32'hDEADBEEF}}; lv = '1; lk = 16'hA5A5;
    cycle("rst0");
    cycle("rst1");
    chk("reset_flags", {out_valid, aligned, deskew_err, ovf_err, skew_cycles, out_k}, '0);
    chk("reset_data", out_data, '0);

    // Four lanes aligned in the same cycle, then two data columns.
    tbl[0] = '{32'hBCBCBCBC, 4'hF, 4'hF, 1'b0, 32'h0,        4'h0, 1'b0, 3'd0};
    tbl[1] = '{32'h04030201, 4'h0, 4'hF, 1'b1, 32'hBCBCBCBC, 4'hF, 1'b1, 3'd0};
    tbl[2] = '{32'h00000000, 4'h0, 4'h0, 1'b1, 32'h04030201, 4'h0, 1'b1, 3'd0};
    tbl[3] = '{32'h00000000, 4'h0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b1, 3'd0};
    tbl[4] = '{32'h44332211, 4'h0, 4'hF, 1'b0, 32'h0,        4'h0, 1'b1, 3'd0};
    tbl[5] = '{32'h00000000, 4'h0, 4'h0, 1'b1, 32'h44332211, 4'h0, 1'b1, 3'd0};
    do_reset(5'd4);
    for (int r = 0; r < 6; r++) begin
      clear_in();
      ldata[31:0] = tbl[r].d; lk[3:0] = tbl[r].k; lv[3:0] = tbl[r].v;
      cycle("t22");
      chk("t22_valid", out_valid, tbl[r].ev);
      chk("t22_data", out_data, {96'b0, tbl[r].ed});
      chk("t22_k", out_k, {12'b0, tbl[r].ek});
      chk("t22_aligned", aligned, tbl[r].eal);
      chk("t22_skew", skew_cycles, tbl[r].esk);
      chk("t22_errs", {deskew_err, ovf_err}, 2'b00);
    end

    // Lane 3 marker three cycles behind lanes 0-2.
    do_reset(5'd4);
    for (int c = 0; c < 16; c++) begin
      clear_in();
      for (int i = 0; i < 3; i++)
        if (c == 0) set_lane(i, 1'b1, 8'hBC);
        else if (c <= 10) set_lane(i, 1'b0, 8'(16*c + i));
      if (c == 3) set_lane(3, 1'b1, 8'hBC);
      else if (c > 3 && c <= 13) set_lane(3, 1'b0, 8'(16*(c-3) + 3));
      cycle("s23");
    end
    chk("s23_skew", skew_cycles, 3'd3);
    chk("s23_ncols", obs.size(), 11);
    if (obs.size() > 0) chk("s23_marker_col", obs[0], 32'hBCBCBCBC);
    for (int j = 1; j <= 10; j++)
      if (j < obs.size()) begin
        w = {8'(16*j+3), 8'(16*j+2), 8'(16*j+1), 8'(16*j)};
        chk("s23_col", obs[j], w);
      end

    // Two lanes, lane 1 marker seven cycles late, then a fresh pair.
    do_reset(5'd2);
    for (int c = 0; c < 15; c++) begin
      clear_in();
      if (c == 0) set_lane(0, 1'b1, 8'hBC);
      if (c == 7) set_lane(1, 1'b1, 8'hBC);
      if (c == 8) set_lane(0, 1'b1, 8'hBC);
      if (c >= 9 && c <= 11) begin
        set_lane(0, 1'b0, 8'(c));
        set_lane(1, 1'b0, 8'(c + 64));
      end
      cycle("s24");
      if (c == 8) chk("s24_noout", obs.size(), 0);
    end
    chk("s24_pulses", desk_pulses, 1);
    chk("s24_aligned", {aligned, skew_cycles}, {1'b1, 3'd1});
    chk("s24_ncols", obs.size(), 4);

    // Eight lanes aligned, then a column mixing markers and data.
    do_reset(5'd8);
    for (int c = 0; c < 5; c++) begin
      clear_in();
      for (int i = 0; i < 8; i++)
        if (c == 0) set_lane(i, 1'b1, 8'hBC);
        else if (c == 1) set_lane(i, 1'b0, 8'(32 + i));
        else if (c == 2) set_lane(i, i == 7 ? 1'b0 : 1'b1, i == 7 ? 8'h77 : 8'hBC);
      cycle("s25");
      if (c == 2) chk("s25_pre", {aligned, out_valid}, 2'b11);
      if (c == 3) chk("s25_err", {deskew_err, aligned, out_valid}, 3'b100);
    end

    // Four lanes aligned, lane 2 stalled while the rest are written nine times.
    do_reset(5'd4);
    for (int c = 0; c < 12; c++) begin
      clear_in();
      if (c == 0) for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 8'hBC);
      else if (c >= 2 && c <= 10)
        for (int i = 0; i < 4; i++) if (i != 2) set_lane(i, 1'b0, 8'(c));
      cycle("s26");
      if (c == 9)  chk("s26_full", {ovf_err, aligned}, 2'b01);
      if (c == 10) chk("s26_ovf", {ovf_err, aligned, deskew_err, out_valid}, 4'b1000);
    end

    // Lane count changes from 4 to 8 with data queued.
    do_reset(5'd4);
    for (int c = 0; c < 4; c++) begin
      clear_in();
      if (c >= 2) ln = 5'd8;
      for (int i = 0; i < 4; i++)
        if (c == 0) set_lane(i, 1'b1, 8'hBC);
        else if (c <= 2) set_lane(i, 1'b0, 8'(80 + i));
      cycle("s26b");
      if (c == 1) chk("s26b_pre", aligned, 1'b1);
      if (c == 2) chk("s26b_chg", {aligned, out_valid, deskew_err, ovf_err}, 4'b0000);
    end

    // Reset mid-stream drops buffered data; data alone cannot realign.
    do_reset(5'd4);
    for (int c = 0; c < 3; c++) begin
      clear_in();
      for (int i = 0; i < 4; i++) set_lane(i, c == 0, c == 0 ? 8'hBC : 8'(c));
      cycle("s27");
    end
    do_reset(5'd4);
    for (int c = 0; c < 6; c++) begin
      clear_in();
      if (c < 3) for (int i = 0; i < 4; i++) set_lane(i, 1'b0, 8'(c + 1));
      cycle("s27b");
    end
    chk("s27_noout", obs.size(), 0);
    chk("s27_aligned", aligned, 1'b0);

    // Randomized traffic against the reference model.
    lnsel[0] = 5'd1; lnsel[1] = 5'd2; lnsel[2] = 5'd4;
    lnsel[3] = 5'd8; lnsel[4] = 5'd16; lnsel[5] = 5'd3;
    for (int blk = 0; blk < 12; blk++) begin
      ln = lnsel[$urandom_range(0, 5)];
      for (int c = 0; c < 250; c++) begin
        clear_in();
        reset = ($urandom_range(0, 299) == 0);
        if (blk % 2 == 1) begin
          if ($urandom_range(0, 4) != 0) begin
            mkr = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < ML; i++)
              if ($urandom_range(0, 19) != 0)
                set_lane(i, mkr, mkr ? 8'hBC : 8'($urandom_range(0, 255)));
          end
        end else begin
          for (int i = 0; i < ML; i++)
            if ($urandom_range(0, 9) < 8) begin
              if ($urandom_range(0, 3) == 0) set_lane(i, 1'b1, 8'hBC);
              else set_lane(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            end
        end
        cycle("rnd");
      end
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
